// File: rtl/euros_para_centimos.sv
// euros_para_centimos: converts whole euros + cents into total centimos using sequential shift-add.
// Define SATURATE_EN to clamp an overflowing result to 2^WIDTH-1 instead of wrapping it.
module euros_para_centimos #(
    parameter int WIDTH          = 10,
    parameter int CENTS_PER_EURO = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] eurosinteiros,
    input  logic [WIDTH-1:0] eurosfracao,
    output logic [WIDTH-1:0] centimos,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             err_fracao
);
    localparam int AW = WIDTH + 8;
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] CPE_W = WIDTH'(CENTS_PER_EURO);
    localparam logic [AW-1:0] CPE_A = AW'(CENTS_PER_EURO);
    localparam logic [AW-1:0] MAX_A = {{8{1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, CHECK, MUL, SUM} state_t;

    state_t state, state_n;
    logic [WIDTH-1:0] ei, ei_n, ef, ef_n, cent_n;
    logic [AW-1:0] acc, acc_n, sum;
    logic [IW-1:0] idx, idx_n;
    logic ovf_n, err_n, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ei         <= '0;
            ef         <= '0;
            acc        <= '0;
            idx        <= '0;
            centimos   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            err_fracao <= 1'b0;
        end else begin
            state      <= state_n;
            ei         <= ei_n;
            ef         <= ef_n;
            acc        <= acc_n;
            idx        <= idx_n;
            centimos   <= cent_n;
            busy       <= state_n != IDLE;
            done       <= done_n;
            overflow   <= ovf_n;
            err_fracao <= err_n;
        end
    end

    assign sum = acc + {8'b0, ef};

    always_comb begin
        state_n = state;
        ei_n    = ei;
        ef_n    = ef;
        acc_n   = acc;
        idx_n   = idx;
        cent_n  = centimos;
        ovf_n   = overflow;
        err_n   = err_fracao;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start) begin
                ei_n    = eurosinteiros;
                ef_n    = eurosfracao;
                acc_n   = '0;
                idx_n   = '0;
                state_n = CHECK;
            end
            CHECK: if (ef >= CPE_W) begin
                cent_n  = '0;
                err_n   = 1'b1;
                ovf_n   = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end else begin
                state_n = MUL;
            end
            MUL: begin
                acc_n   = ei[idx] ? acc + (CPE_A << idx) : acc;
                idx_n   = idx + 1'b1;
                state_n = (idx == IW'(WIDTH - 1)) ? SUM : MUL;
            end
            default: begin
                ovf_n   = sum > MAX_A;
`ifdef SATURATE_EN
                cent_n  = (sum > MAX_A) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                cent_n  = sum[WIDTH-1:0];
`endif
                err_n   = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_euros_para_centimos.sv
// tb_euros_para_centimos: directed checks of the euros-to-centimos converter.
module tb_euros_para_centimos;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [9:0] eurosinteiros = '0;
    logic [9:0] eurosfracao = '0;
    logic [9:0] centimos;
    logic busy, done, overflow, err_fracao;
    int checks = 0;
    int errors = 0;

`ifdef SATURATE_EN
    localparam logic [9:0] OVF_CENT = 10'd1023;
`else
    localparam logic [9:0] OVF_CENT = 10'd0;
`endif

    euros_para_centimos dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .eurosinteiros(eurosinteiros), .eurosfracao(eurosfracao),
        .centimos(centimos), .busy(busy), .done(done),
        .overflow(overflow), .err_fracao(err_fracao)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge just after the sampling edge E0.
    task automatic start_conv(input logic [9:0] a, input logic [9:0] b);
        eurosinteiros = a;
        eurosfracao = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        eurosinteiros = 10'h3ff;
        eurosfracao = 10'h3ff;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (centimos !== 10'd0) begin errors++; $display("FAIL reset_centimos got %0d want 0", centimos); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (err_fracao !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_fracao); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        start_conv(10'd1, 10'd50);
        for (int k = 0; k < 12; k++) begin
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_busy E%0d got busy=%b done=%b want busy=1 done=0", k, busy, done); end
            @(negedge clk);
        end
        checks++; if (centimos !== 10'd150) begin errors++; $display("FAIL basic_centimos got %0d want 150", centimos); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b busy=%b want done=1 busy=0", done, busy); end
        checks++; if (overflow !== 1'b0 || err_fracao !== 1'b0) begin errors++; $display("FAIL basic_flags got ovf=%b err=%b want 0 0", overflow, err_fracao); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || centimos !== 10'd150) begin errors++; $display("FAIL basic_hold got done=%b cent=%0d want done=0 cent=150", done, centimos); end
    endtask

    task automatic test_values;
        start_conv(10'd0, 10'd0);
        repeat (12) @(negedge clk);
        checks++; if (centimos !== 10'd0 || done !== 1'b1) begin errors++; $display("FAIL zero got cent=%0d done=%b want 0 1", centimos, done); end
        start_conv(10'd10, 10'd23);
        repeat (12) @(negedge clk);
        checks++; if (centimos !== 10'd1023 || overflow !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL max got cent=%0d ovf=%b done=%b want 1023 0 1", centimos, overflow, done); end
        start_conv(10'd10, 10'd24);
        repeat (12) @(negedge clk);
        checks++; if (centimos !== OVF_CENT || overflow !== 1'b1) begin errors++; $display("FAIL overflow got cent=%0d ovf=%b want %0d 1", centimos, overflow, OVF_CENT); end
        start_conv(10'd5, 10'd99);
        repeat (12) @(negedge clk);
        checks++; if (centimos !== 10'd599 || overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf got cent=%0d ovf=%b want 599 0", centimos, overflow); end
    endtask

    task automatic test_err;
        start_conv(10'd3, 10'd100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_busy got %b want 1", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || err_fracao !== 1'b1 || centimos !== 10'd0 || busy !== 1'b0) begin errors++; $display("FAIL err_result got done=%b err=%b cent=%0d busy=%b want 1 1 0 0", done, err_fracao, centimos, busy); end
        start_conv(10'd2, 10'd5);
        checks++; if (err_fracao !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL err_hold got err=%b busy=%b want 1 1", err_fracao, busy); end
        repeat (12) @(negedge clk);
        checks++; if (centimos !== 10'd205 || err_fracao !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL err_followup got cent=%0d err=%b done=%b want 205 0 1", centimos, err_fracao, done); end
    endtask

    task automatic test_back_to_back;
        start_conv(10'd1, 10'd50);
        repeat (4) @(negedge clk);
        start_conv(10'd9, 10'd99);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        repeat (7) @(negedge clk);
        checks++; if (centimos !== 10'd150 || done !== 1'b1) begin errors++; $display("FAIL b2b_ignored got cent=%0d done=%b want 150 1", centimos, done); end
        start_conv(10'd9, 10'd99);
        checks++; if (busy !== 1'b1 || centimos !== 10'd150) begin errors++; $display("FAIL b2b_accept got busy=%b cent=%0d want 1 150", busy, centimos); end
        repeat (12) @(negedge clk);
        checks++; if (centimos !== 10'd999 || done !== 1'b1) begin errors++; $display("FAIL b2b_second got cent=%0d done=%b want 999 1", centimos, done); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        start_conv(10'd7, 10'd7);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (centimos !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || err_fracao !== 1'b0) begin errors++; $display("FAIL mid_reset got cent=%0d busy=%b done=%b ovf=%b err=%b want all 0", centimos, busy, done, overflow, err_fracao); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= done | busy;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_done got activity=%b want 0", seen); end
        start_conv(10'd7, 10'd7);
        repeat (12) @(negedge clk);
        checks++; if (centimos !== 10'd707 || done !== 1'b1) begin errors++; $display("FAIL mid_restart got cent=%0d done=%b want 707 1", centimos, done); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values;
        test_err;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
